// File: rtl/line_byte_reader_pkg.sv
// Shared cache definitions for the line byte reader: default geometry and FSM states.
package line_byte_reader_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LINE_BYTES = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/dataByte.sv
// Single byte storage cell: loads d when write is high, clears on reset.
module dataByte (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] byte_q;
  logic [7:0] byte_d;

  always_comb begin
    if (write) begin
      byte_d = d;
    end else begin
      byte_d = byte_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign q = byte_q;

endmodule

// File: rtl/line_buffer.sv
// Capture buffer for one cache line built from byte cells, with an offset-indexed read mux.
module line_buffer #(
  parameter  int LINE_BYTES = 16,
  localparam int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [LINE_BYTES*8-1:0] line_data,
  input  logic [OFF_W-1:0]        offset,
  output logic [7:0]              rd_data
);

  logic [7:0] cell_q [LINE_BYTES];

  for (genvar i = 0; i < LINE_BYTES; i++) begin : g_cell
    dataByte u_cell (
      .clk   (clk),
      .reset (reset),
      .write (write),
      .d     (line_data[8*i +: 8]),
      .q     (cell_q[i])
    );
  end

  assign rd_data = cell_q[offset];

endmodule

// File: rtl/line_byte_reader.sv
// Captures a cache line on start and streams it out one byte per valid/ready handshake,
// tagging each byte with its full address and a last flag, then pulses done.
module line_byte_reader
  import line_byte_reader_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int LINE_BYTES = DEF_LINE_BYTES,
  localparam int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [ADDR_W-OFF_W-1:0] line_addr,
  input  logic [LINE_BYTES*8-1:0] line_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_BYTES - 1);

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [ADDR_W-OFF_W-1:0] addr_q, addr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic                    start_ready_q, start_ready_d;
  logic                    done_q, done_d;
  logic                    accept_s;
  logic [OFF_W-1:0]        offset_inc_s;

  assign accept_s     = (state_q == IDLE) && start;
  assign offset_inc_s = offset_q + OFF_W'(1);

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    addr_d        = addr_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    start_ready_d = start_ready_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = SEND;
          offset_d      = '0;
          addr_d        = line_addr;
          out_valid_d   = 1'b1;
          out_last_d    = 1'b0;
          busy_d        = 1'b1;
          start_ready_d = 1'b0;
        end else begin
          start_ready_d = 1'b1;
        end
      end
      SEND: begin
        if (out_ready && (offset_q == LAST_OFF)) begin
          state_d       = IDLE;
          offset_d      = '0;
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
          busy_d        = 1'b0;
          start_ready_d = 1'b1;
          done_d        = 1'b1;
        end else if (out_ready) begin
          offset_d   = offset_inc_s;
          out_last_d = (offset_inc_s == LAST_OFF);
        end else begin
          offset_d = offset_q;
        end
      end
      default: begin
        state_d       = IDLE;
        offset_d      = '0;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        busy_d        = 1'b0;
        start_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      offset_q      <= '0;
      addr_q        <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      addr_q        <= addr_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
      done_q        <= done_d;
    end
  end

  // Byte storage only loads on an accepted start, so it is stable for the whole stream.
  line_buffer #(.LINE_BYTES(LINE_BYTES)) u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .write     (accept_s),
    .line_data (line_data),
    .offset    (offset_q),
    .rd_data   (out_data)
  );

  assign out_addr    = {addr_q, offset_q};
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign start_ready = start_ready_q;
  assign done        = done_q;

endmodule

// File: tb/tb_line_byte_reader.sv
// Directed self-checking bench for line_byte_reader (32-bit addresses, 16-byte lines).
module tb_line_byte_reader;

  localparam int AW = 32;
  localparam int LB = 16;

  logic            clk = 1'b0;
  logic            reset, start, out_ready;
  logic [27:0]     line_addr;
  logic [LB*8-1:0] line_data;
  logic            start_ready, out_valid, out_last, busy, done;
  logic [7:0]      out_data;
  logic [AW-1:0]   out_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  line_byte_reader #(.ADDR_W(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .line_addr(line_addr), .line_data(line_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [LB*8-1:0] make_line(input logic [7:0] base);
    logic [LB*8-1:0] r;
    for (int i = 0; i < LB; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; line_addr = 28'h0; line_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({start_ready, out_valid, done, busy, out_last} !== 5'b10000 || out_data !== 8'h00 || out_addr !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d: got rdy/vld/done/busy/last=%b data=%h addr=%h, want 10000 00 00000000",
                 c, {start_ready, out_valid, done, busy, out_last}, out_data, out_addr);
      end
    end
  endtask

  task automatic test_basic_stream();
    line_addr = 28'h0ABCDEF; line_data = make_line(8'h10); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; line_data = {LB{8'h5A}}; line_addr = 28'hFFFFFFF;
    for (int i = 0; i < LB; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i) || out_addr !== 32'h0ABCDEF0 + 32'(i) ||
          out_last !== (i == LB - 1) || busy !== 1'b1 || start_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_byte%0d: got vld=%b data=%h addr=%h last=%b busy=%b rdy=%b, want 1 %h %h %b 1 0",
                 i, out_valid, out_data, out_addr, out_last, busy, start_ready,
                 8'h10 + 8'(i), 32'h0ABCDEF0 + 32'(i), (i == LB - 1));
      end
      @(negedge clk);
    end
    tests_run++;
    if ({done, out_valid, start_ready, busy} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL basic_done: got done/vld/rdy/busy=%b, want 1010", {done, out_valid, start_ready, busy});
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_backpressure();
    int         idx = 0;
    int         stalls = 0;
    int         xfers = 0;
    bit         seen_done = 1'b0;
    bit         was_stalled = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [31:0] prev_addr = 32'h0;
    line_addr = 28'h0000123; line_data = make_line(8'h40); start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
      end else if (out_valid) begin
        tests_run++;
        if (idx >= LB || out_data !== 8'h40 + 8'(idx) || out_addr !== 32'h00001230 + 32'(idx) || out_last !== (idx == LB - 1)) begin
          tests_failed++;
          $display("FAIL bp_byte%0d: got data=%h addr=%h last=%b, want %h %h %b",
                   idx, out_data, out_addr, out_last, 8'h40 + 8'(idx), 32'h00001230 + 32'(idx), (idx == LB - 1));
        end
        if (was_stalled) begin
          tests_run++;
          if (out_data !== prev_data || out_addr !== prev_addr) begin
            tests_failed++;
            $display("FAIL bp_stable: got data=%h addr=%h, want %h %h", out_data, out_addr, prev_data, prev_addr);
          end
        end
        if (idx == 5 && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        was_stalled = !out_ready;
        prev_data = out_data;
        prev_addr = out_addr;
        if (out_ready) begin
          idx++;
          xfers++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!seen_done || xfers != LB || stalls != 3) begin
      tests_failed++;
      $display("FAIL bp_total: got done_seen=%0d transfers=%0d stalls=%0d, want 1 16 3", seen_done, xfers, stalls);
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    line_addr = 28'h0000055; line_data = make_line(8'h60); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < LB; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h60 + 8'(i) || out_addr !== 32'h00000550 + 32'(i)) begin
        tests_failed++;
        $display("FAIL ign_byte%0d: got vld=%b data=%h addr=%h, want 1 %h %h",
                 i, out_valid, out_data, out_addr, 8'h60 + 8'(i), 32'h00000550 + 32'(i));
      end
      if (i == 7) begin
        start = 1'b1; line_data = {LB{8'hEE}}; line_addr = 28'h0000999;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ign_done: got done=%b, want 1", done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL ign_no_second cyc=%0d: got vld=%b busy=%b, want 0 0", c, out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    line_addr = 28'h0000777; line_data = make_line(8'h20); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LB) @(negedge clk);
    tests_run++;
    if ({done, start_ready, out_valid} !== 3'b110) begin
      tests_failed++;
      $display("FAIL b2b_done_cycle: got done/rdy/vld=%b, want 110", {done, start_ready, out_valid});
    end
    start = 1'b1; line_addr = 28'h0000001; line_data = make_line(8'h30);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < LB; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h30 + 8'(i) || out_addr !== 32'h00000010 + 32'(i) || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_byte%0d: got vld=%b data=%h addr=%h done=%b, want 1 %h %h 0",
                 i, out_valid, out_data, out_addr, done, 8'h30 + 8'(i), 32'h00000010 + 32'(i));
      end
      @(negedge clk);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done2: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    line_addr = 28'h00000AB; line_data = make_line(8'h70); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    tests_run++;
    if (out_data !== 8'h79 || out_addr !== 32'h00000AB9) begin
      tests_failed++;
      $display("FAIL mr_pre: got data=%h addr=%h, want 79 00000ab9", out_data, out_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({out_valid, start_ready, busy, done, out_last} !== 5'b01000 || out_data !== 8'h00 || out_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL mr_abort: got vld/rdy/busy/done/last=%b data=%h addr=%h, want 01000 00 00000000",
               {out_valid, start_ready, busy, done, out_last}, out_data, out_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mr_no_done cyc=%0d: got done=%b vld=%b, want 0 0", c, done, out_valid);
      end
    end
    line_addr = 28'h00000CD; line_data = make_line(8'h90); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < LB; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h90 + 8'(i) || out_addr !== 32'h00000CD0 + 32'(i)) begin
        tests_failed++;
        $display("FAIL mr_restart_byte%0d: got vld=%b data=%h addr=%h, want 1 %h %h",
                 i, out_valid, out_data, out_addr, 8'h90 + 8'(i), 32'h00000CD0 + 32'(i));
      end
      @(negedge clk);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL mr_restart_done: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/line_byte_reader.md
Name: line_byte_reader

Overview:
Read side of the cache line byte storage. On a start request it captures one full cache line and its line address, then streams the line out one byte per handshake on a valid/ready interface. The consumer is the write-back / refill path to memory. Each byte carries its full byte address and a last flag, and a done pulse follows completion.

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 16, bytes per cache line; must be a power of 2, minimum 2
OFF_W, $clog2(LINE_BYTES), byte-offset width; localparam derived from LINE_BYTES, not overridable

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to read out a line
start_ready  output  1  block is idle and can accept start
line_addr  input  ADDR_W-OFF_W  line address (byte address upper bits), sampled on accepted start
line_data  input  LINE_BYTES*8  line contents; byte i = line_data[8i+7:8i]; sampled on accepted start
out_valid  output  1  out_data/out_addr/out_last valid
out_ready  input  1  consumer accepts the current byte
out_data  output  8  current byte
out_addr  output  ADDR_W  {captured line_addr, offset}
out_last  output  1  current byte is offset LINE_BYTES-1
busy  output  1  high from accepted start until the final handshake
done  output  1  one-cycle pulse in the cycle after the final handshake

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: start_ready=1, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0. Offset counter=0. Capture buffer=0.
- FSM states: IDLE and SEND.
- IDLE:
  - start_ready=1.
  - If start=1: capture line_data and line_addr, set offset=0, go to SEND. This is an accepted start.
- SEND:
  - out_valid=1, out_data=buffer byte[offset], out_addr={addr_reg, offset}, out_last=(offset==LINE_BYTES-1).
  - start_ready=0, busy=1.
- Latency: first byte is valid in the cycle after the accepted start.
- Handshake:
  - A transfer occurs on a clk edge with out_valid&&out_ready.
  - With out_ready=0, all outputs hold stable; the counter and buffer do not change.
  - out_valid never drops without a transfer, except on reset.
  - Full throughput: with out_ready held high, one byte per cycle, LINE_BYTES cycles per line.
- Non-last transfer: offset+1, stay in SEND.
- Last transfer (offset==LINE_BYTES-1): go to IDLE, offset wraps to 0, done=1 for exactly the next cycle.
- done and start_ready are both high in that cycle. A start there is accepted, giving back-to-back lines with a 1-cycle gap in out_valid.
- start while in SEND is ignored. line_data and line_addr are don't-care outside the accepted-start cycle.
- out_addr offset field is the counter; the upper bits come from the captured line_addr and never carry.
- Reset mid-stream aborts immediately: next cycle matches reset values, no done pulse, the partial line is discarded.
- reset has priority over start and handshakes in the same cycle.

Decomposition:
- Shared cache package: LINE_BYTES, OFF_W, ADDR_W defaults, and the FSM state enum {IDLE, SEND}.
- One sub-module: line_buffer.
  - Contents: LINE_BYTES instances of the existing dataByte byte cell, all written with write=accepted start.
  - Read-out: an OFF_W-bit mux that selects byte[offset].
- Counter, address register and FSM stay in line_byte_reader.

Test Plan:
- Reset then idle: start_ready=1, out_valid=0, done=0 for 5 cycles.
- Basic stream: LINE_BYTES=16, line_addr=0x0ABCDEF, line_data byte i=0x10+i, out_ready=1.
  - First out_valid is the cycle after start.
  - Bytes 0x10..0x1F appear at out_addr 0xABCDEF0..0xABCDEFF, out_last only on 0x1F.
  - done pulses once in the following cycle.
- Backpressure: toggle out_ready randomly, holding it 0 for 3 cycles at offset 5. Outputs are stable while stalled, every byte is delivered exactly once in order, total transfers=16.
- Ignored start: pulse start with different line_data at offset 7. The stream is unchanged and no second line follows.
- Back-to-back: assert start in the done cycle with line_addr=0x1. The second line's first byte is at out_addr 0x10 two cycles after the first line's last handshake.
- Mid-stream reset: reset at offset 9. The next cycle has out_valid=0, start_ready=1, and done never pulses. A new start afterward streams from offset 0.
